// File: rtl/daa_pkg.sv
// Shared types and default widths for the arithmetic datapath blocks.
package daa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DW    = 16;
    localparam int DIV_VW    = 8;
    localparam int DIV_CNT_W = $clog2(DIV_DW + 1);

endpackage

// File: rtl/daa_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if it fits.
module daa_div_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] pr_in,
    input  logic          msb_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] pr_out,
    output logic          qbit
);

    logic [VW:0] shifted;

    // The extra top bit keeps the compare exact; after a subtract the result
    // is below the divisor, so a VW-bit difference is sufficient.
    always_comb begin
        shifted = {pr_in, msb_in};
        qbit    = (shifted >= {1'b0, divisor});
        pr_out  = qbit ? (shifted[VW-1:0] - divisor) : shifted[VW-1:0];
    end

endmodule

// File: rtl/daa_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on the operand and result sides.
module daa_seq_divider
    import daa_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CNT_W = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DW - 1);

    div_state_t     state_q, state_d;
    logic [DW-1:0]  dq_q, dq_d;
    logic [VW-1:0]  pr_q, pr_d;
    logic [VW-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  quotient_q, quotient_d;
    logic [VW-1:0]  remainder_q, remainder_d;
    logic           dbz_q, dbz_d;

    logic [VW-1:0]  step_pr;
    logic           step_qbit;

    daa_div_step #(.VW(VW)) u_step (
        .pr_in   (pr_q),
        .msb_in  (dq_q[DW-1]),
        .divisor (dvs_q),
        .pr_out  (step_pr),
        .qbit    (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        dq_d        = dq_q;
        pr_d        = pr_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvs_d = divisor;
                    dq_d  = dividend;
                    pr_d  = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dq_d  = {dq_q[DW-2:0], step_qbit};
                pr_d  = step_pr;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quotient_d  = {dq_q[DW-2:0], step_qbit};
                    remainder_d = step_pr;
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                // Divide-by-zero enters here with out_valid low; raise it one edge later.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dq_q        <= '0;
            pr_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_q        <= dq_d;
            pr_q        <= pr_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_daa_seq_divider.sv
// Directed-vector bench for daa_seq_divider with hand-computed results.
module tb_daa_seq_divider;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int tests_run;
    int tests_failed;

    daa_seq_divider #(.DW(16), .VW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the accept edge, then scramble the inputs.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = b + 8'd3;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                         input int exp_lat);
        start_op(a, b);
        wait_result(tag, exp_lat);
        check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        consume();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        dividend     = '0;
        divisor      = '0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q", {16'd0, quotient}, 32'd0);
        check("rst_r", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        tick();

        do_op("basic", 16'h1E61, 8'h2B, 16'h00B4, 8'h25, 1'b0, 16);
        do_op("sq255", 16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0, 16);
        do_op("div1",  16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16);
        do_op("small", 16'h0005, 8'h07, 16'h0000, 8'h05, 1'b0, 16);
        do_op("zero",  16'h0000, 8'h09, 16'h0000, 8'h00, 1'b0, 16);
        do_op("dbz",   16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1);
        do_op("after_dbz", 16'h0010, 8'h04, 16'h0004, 8'h00, 1'b0, 16);

        // Back-pressure: result must hold and new operands be ignored.
        start_op(16'h1E61, 8'h2B);
        wait_result("hold", 16);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 16'h0100;
            divisor  = 8'h02;
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_q", {16'd0, quotient}, 32'h00B4);
            check("hold_r", {24'd0, remainder}, 32'h25);
        end
        in_valid = 1'b0;
        consume();
        // The ignored pulses must not have started an operation.
        tick();
        tick();
        check("no_ghost_op_ready", {31'd0, in_ready}, 32'd1);
        check("no_ghost_op_valid", {31'd0, out_valid}, 32'd0);

        // Reset partway through an operation.
        start_op(16'hABCD, 8'h12);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_q", {16'd0, quotient}, 32'd0);
        check("midrst_r", {24'd0, remainder}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("postrst_no_result", {31'd0, out_valid}, 32'd0);
        do_op("postrst", 16'hABCD, 8'h12, 16'h098B, 8'h07, 1'b0, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
